// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register slice:
// control-vector layout, opcode constants and a packing helper.
package id_ex_stage_pkg;

    localparam int CTRL_W = 6;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Bit positions inside the control vector, MSB first.
    localparam int C_REGWRITE = 5;
    localparam int C_MEMREAD  = 4;
    localparam int C_MEMWRITE = 3;
    localparam int C_MEMTOREG = 2;
    localparam int C_REGDST   = 1;
    localparam int C_ALUSRC   = 0;

    localparam ctrl_t NOP_CTRL = '0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    function automatic ctrl_t pack_ctrl(
        input logic rw,
        input logic mr,
        input logic mw,
        input logic mtr,
        input logic rdst,
        input logic asrc
    );
        return {rw, mr, mw, mtr, rdst, asrc};
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use detector driving the upstream write enables.
// A taken flush suppresses the stall so the redirect goes through.
module hazard_detect_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              exValid,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              flush,
    input  logic              hold,
    output logic              stallReq,
    output logic              pcWrite,
    output logic              ifIdWrite
);

    logic load_use;

    assign load_use  = exValid & exMemRead & (exRt != '0)
                     & ((exRt == idRs) | (exRt == idRt));
    assign stallReq  = load_use & ~flush;
    assign pcWrite   = ~(hold | stallReq);
    assign ifIdWrite = ~(hold | stallReq);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, flush, hold
// and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memToReg,
    input  logic              regDst,
    input  logic              ALUSrc,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] signExtImm,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic [REG_AW-1:0] idRd,
    input  logic              flush,
    input  logic              hold,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              exRegDst,
    output logic              exALUSrc,
    output logic [DATA_W-1:0] exData1,
    output logic [DATA_W-1:0] exData2,
    output logic [DATA_W-1:0] exImm,
    output logic [REG_AW-1:0] exRs,
    output logic [REG_AW-1:0] exRt,
    output logic [REG_AW-1:0] exRd,
    output logic              exValid,
    output logic              pcWrite,
    output logic              ifIdWrite,
    output logic [CNT_W-1:0]  stallCount
);

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    logic [DATA_W-1:0] d2_q, d2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_req;

    hazard_detect_unit #(
        .REG_AW (REG_AW)
    ) u_hdu (
        .exValid   (valid_q),
        .exMemRead (ctrl_q[C_MEMREAD]),
        .exRt      (rt_q),
        .idRs      (idRs),
        .idRt      (idRt),
        .flush     (flush),
        .hold      (hold),
        .stallReq  (stall_req),
        .pcWrite   (pcWrite),
        .ifIdWrite (ifIdWrite)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            d1_d  = readData1;
            d2_d  = readData2;
            imm_d = signExtImm;
            rs_d  = idRs;
            rt_d  = idRt;
            rd_d  = idRd;
            // Flush and bubble both squash control but keep the data path loaded.
            if (flush || stall_req) begin
                ctrl_d  = NOP_CTRL;
                valid_d = 1'b0;
            end else begin
                ctrl_d  = pack_ctrl(regWrite, memRead, memWrite,
                                    memToReg, regDst, ALUSrc);
                valid_d = 1'b1;
            end
            if (stall_req && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= NOP_CTRL;
            d1_q    <= '0;
            d2_q    <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exRegWrite = ctrl_q[C_REGWRITE];
    assign exMemRead  = ctrl_q[C_MEMREAD];
    assign exMemWrite = ctrl_q[C_MEMWRITE];
    assign exMemToReg = ctrl_q[C_MEMTOREG];
    assign exRegDst   = ctrl_q[C_REGDST];
    assign exALUSrc   = ctrl_q[C_ALUSRC];
    assign exData1    = d1_q;
    assign exData2    = d2_q;
    assign exImm      = imm_q;
    assign exRs       = rs_q;
    assign exRt       = rt_q;
    assign exRd       = rd_q;
    assign exValid    = valid_q;
    assign stallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, an abstract slot model checked
// every cycle, and a narrow-counter instance sharing the same stimulus.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          regWrite, memRead, memWrite, memToReg, regDst, ALUSrc;
    logic [DW-1:0] readData1, readData2, signExtImm;
    logic [AW-1:0] idRs, idRt, idRd;
    logic          flush, hold;

    logic          exRegWrite, exMemRead, exMemWrite, exMemToReg, exRegDst, exALUSrc;
    logic [DW-1:0] exData1, exData2, exImm;
    logic [AW-1:0] exRs, exRt, exRd;
    logic          exValid, pcWrite, ifIdWrite;
    logic [15:0]   stallCount;

    logic          s_RegWrite, s_MemRead, s_MemWrite, s_MemToReg, s_RegDst, s_ALUSrc;
    logic [DW-1:0] s_Data1, s_Data2, s_Imm;
    logic [AW-1:0] s_Rs, s_Rt, s_Rd;
    logic          s_Valid, s_pcWrite, s_ifIdWrite;
    logic [3:0]    s_stallCount;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .regDst(regDst), .ALUSrc(ALUSrc),
        .readData1(readData1), .readData2(readData2), .signExtImm(signExtImm),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .flush(flush), .hold(hold),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exMemToReg(exMemToReg), .exRegDst(exRegDst), .exALUSrc(exALUSrc),
        .exData1(exData1), .exData2(exData2), .exImm(exImm),
        .exRs(exRs), .exRt(exRt), .exRd(exRd),
        .exValid(exValid), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
        .stallCount(stallCount)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .memToReg(memToReg), .regDst(regDst), .ALUSrc(ALUSrc),
        .readData1(readData1), .readData2(readData2), .signExtImm(signExtImm),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .flush(flush), .hold(hold),
        .exRegWrite(s_RegWrite), .exMemRead(s_MemRead), .exMemWrite(s_MemWrite),
        .exMemToReg(s_MemToReg), .exRegDst(s_RegDst), .exALUSrc(s_ALUSrc),
        .exData1(s_Data1), .exData2(s_Data2), .exImm(s_Imm),
        .exRs(s_Rs), .exRt(s_Rt), .exRd(s_Rd),
        .exValid(s_Valid), .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite),
        .stallCount(s_stallCount)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Abstract model: what the EX slot should hold and how many bubbles so far.
    logic [5:0]    m_ctrl;
    logic [DW-1:0] m_d1, m_d2, m_imm;
    logic [AW-1:0] m_rs, m_rt, m_rd;
    logic          m_v;
    int            m_stalls;
    bit            m_ok = 1'b0;

    function automatic bit m_lu();
        return m_v && m_ctrl[4] && (m_rt != 0) && ((m_rt == idRs) || (m_rt == idRt));
    endfunction

    always @(posedge clk) begin
        bit lu;
        if (!rst) begin
            m_ctrl = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
            m_rs = '0; m_rt = '0; m_rd = '0; m_v = 1'b0;
            m_stalls = 0;
            m_ok = 1'b1;
        end else if (!hold) begin
            lu = m_lu();
            m_d1 = readData1; m_d2 = readData2; m_imm = signExtImm;
            m_rs = idRs; m_rt = idRt; m_rd = idRd;
            if (flush || lu) begin
                m_ctrl = '0;
                m_v = 1'b0;
                if (!flush) m_stalls++;
            end else begin
                m_ctrl = {regWrite, memRead, memWrite, memToReg, regDst, ALUSrc};
                m_v = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("ctrl", 64'({exRegWrite, exMemRead, exMemWrite, exMemToReg, exRegDst, exALUSrc}), 64'(m_ctrl));
            chk("data1", 64'(exData1), 64'(m_d1));
            chk("data2", 64'(exData2), 64'(m_d2));
            chk("imm", 64'(exImm), 64'(m_imm));
            chk("regs", 64'({exRs, exRt, exRd}), 64'({m_rs, m_rt, m_rd}));
            chk("valid", 64'(exValid), 64'(m_v));
            chk("pcWrite", 64'(pcWrite), 64'(!(hold || (m_lu() && !flush))));
            chk("ifIdWrite", 64'(ifIdWrite), 64'(!(hold || (m_lu() && !flush))));
            chk("count", 64'(stallCount), 64'((m_stalls > 65535) ? 65535 : m_stalls));
            chk("count4", 64'(s_stallCount), 64'((m_stalls > 15) ? 15 : m_stalls));
            chk("ctrl4", 64'({s_RegWrite, s_MemRead, s_Valid}), 64'({m_ctrl[5], m_ctrl[4], m_v}));
        end
    end

    task automatic setc(input logic [5:0] c);
        {regWrite, memRead, memWrite, memToReg, regDst, ALUSrc} = c;
    endtask

    task automatic seti(input logic [5:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] im, input logic [AW-1:0] s,
                        input logic [AW-1:0] t, input logic [AW-1:0] d);
        setc(c);
        readData1 = a; readData2 = b; signExtImm = im;
        idRs = s; idRt = t; idRd = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
        seti(6'b111111, 32'hDEAD, 32'hBEEF, 32'h1234, 5'd3, 5'd4, 5'd5);
        step(); step();
        chk("rst_valid", 64'(exValid), 64'd0);
        chk("rst_regwrite", 64'(exRegWrite), 64'd0);
        chk("rst_data1", 64'(exData1), 64'd0);
        chk("rst_count", 64'(stallCount), 64'd0);
        chk("rst_pcwrite", 64'(pcWrite), 64'd1);

        rst = 1'b1;
        seti(6'b100010, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
        step();
        chk("add_regwrite", 64'(exRegWrite), 64'd1);
        chk("add_regdst", 64'(exRegDst), 64'd1);
        chk("add_data1", 64'(exData1), 64'd5);
        chk("add_data2", 64'(exData2), 64'd7);
        chk("add_rd", 64'(exRd), 64'd3);
        chk("add_valid", 64'(exValid), 64'd1);

        seti(6'b110101, 32'd1, 32'd2, 32'd16, 5'd9, 5'd8, 5'd0);
        step();
        seti(6'b100010, 32'd11, 32'd12, 32'd0, 5'd8, 5'd2, 5'd4);
        #1;
        chk("lu_pcwrite", 64'(pcWrite), 64'd0);
        chk("lu_ifidwrite", 64'(ifIdWrite), 64'd0);
        step();
        chk("bub_valid", 64'(exValid), 64'd0);
        chk("bub_memread", 64'(exMemRead), 64'd0);
        chk("bub_count", 64'(stallCount), 64'd1);
        chk("bub_pcwrite", 64'(pcWrite), 64'd1);
        step();
        chk("adv_valid", 64'(exValid), 64'd1);
        chk("adv_rd", 64'(exRd), 64'd4);

        seti(6'b110101, 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd0);
        step();
        seti(6'b100010, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd6);
        #1;
        chk("r0_pcwrite", 64'(pcWrite), 64'd1);
        step();
        chk("r0_valid", 64'(exValid), 64'd1);
        chk("r0_count", 64'(stallCount), 64'd1);

        seti(6'b110101, 32'd0, 32'd0, 32'd8, 5'd1, 5'd4, 5'd0);
        step();
        seti(6'b100010, 32'd3, 32'd3, 32'd0, 5'd4, 5'd1, 5'd2);
        flush = 1'b1;
        #1;
        chk("fl_pcwrite", 64'(pcWrite), 64'd1);
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(exValid), 64'd0);
        chk("fl_regwrite", 64'(exRegWrite), 64'd0);
        chk("fl_rs", 64'(exRs), 64'd4);
        chk("fl_count", 64'(stallCount), 64'd1);

        seti(6'b100010, 32'hAA, 32'hBB, 32'd0, 5'd1, 5'd2, 5'd7);
        step();
        seti(6'b110101, 32'h55, 32'h66, 32'd9, 5'd2, 5'd7, 5'd0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) flush = 1'b1;
            step();
            chk("hold_data1", 64'(exData1), 64'hAA);
            chk("hold_rd", 64'(exRd), 64'd7);
            chk("hold_pcwrite", 64'(pcWrite), 64'd0);
        end
        hold = 1'b0; flush = 1'b0;
        step();

        seti(6'b110101, 32'd0, 32'd0, 32'd0, 5'd1, 5'd5, 5'd0);
        step();
        seti(6'b100010, 32'd0, 32'd0, 32'd0, 5'd5, 5'd1, 5'd2);
        hold = 1'b1;
        step();
        chk("hb_memread", 64'(exMemRead), 64'd1);
        chk("hb_count", 64'(stallCount), 64'd1);
        hold = 1'b0;
        step();
        chk("hb_bubble", 64'(exValid), 64'd0);
        chk("hb_count2", 64'(stallCount), 64'd2);

        seti(6'b110101, 32'd0, 32'd0, 32'd0, 5'd1, 5'd6, 5'd0);
        step();
        seti(6'b100010, 32'd0, 32'd0, 32'd0, 5'd6, 5'd1, 5'd2);
        rst = 1'b0;
        step();
        chk("mr_valid", 64'(exValid), 64'd0);
        chk("mr_memread", 64'(exMemRead), 64'd0);
        chk("mr_count", 64'(stallCount), 64'd0);
        chk("mr_count4", 64'(s_stallCount), 64'd0);
        chk("mr_pcwrite", 64'(pcWrite), 64'd1);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            seti(6'b110101, 32'(i), 32'd0, 32'd0, 5'd1, 5'd9, 5'd0);
            step();
            seti(6'b100010, 32'd0, 32'(i), 32'd0, 5'd9, 5'd3, 5'd2);
            step();
        end
        chk("sat_count16", 64'(stallCount), 64'd20);
        chk("sat_count4", 64'(s_stallCount), 64'd15);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline stage directly downstream of the main decode controller.
- Latches the controller's six control bits, register-file operands, immediate and register specifiers into the ID/EX register.
- Detects load-use hazards and inserts bubbles, honours branch flush and downstream hold, and counts inserted stall cycles.
- Feeds the EX stage (ALU, forwarding) and drives the PC/IF-ID write enables.

Parameters:
- DATA_W, 32, operand and immediate width
- REG_AW, 5, register specifier width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- regWrite, memRead, memWrite, memToReg, regDst, ALUSrc  in  1 each  decode control bits for the ID instruction
- readData1, readData2  in  DATA_W  register-file outputs
- signExtImm  in  DATA_W  sign-extended immediate
- idRs, idRt, idRd  in  REG_AW  ID instruction specifiers
- flush  in  1  branch/jump taken; ID instruction is wrong-path
- hold  in  1  downstream memory not ready; freeze stage
- exRegWrite, exMemRead, exMemWrite, exMemToReg, exRegDst, exALUSrc  out  1 each  registered control
- exData1, exData2, exImm  out  DATA_W  registered operands
- exRs, exRt, exRd  out  REG_AW  registered specifiers
- exValid  out  1  EX slot holds a real instruction
- pcWrite, ifIdWrite  out  1  upstream write enables (combinational)
- stallCount  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst==0 at clk edge): all ex* outputs 0, exValid 0, stallCount 0. Reset overrides every other input.
- loadUse (combinational) = exValid & exMemRead & (exRt != 0) & ((exRt == idRs) | (exRt == idRt)).
- stallReq = loadUse & ~flush.
- pcWrite = ifIdWrite = ~(hold | stallReq). Combinational; during reset assertion they follow the cleared register state.
- Per-edge priority, highest first:
  - rst: clear.
  - hold: all registers retain their value, and stallCount is unchanged.
  - flush: control bits and exValid load 0; data and specifier fields load the inputs; no count.
  - stallReq: bubble. Same loading as flush (control and exValid cleared, data loaded); stallCount increments.
  - Otherwise: all fields load the inputs, and exValid loads 1.
- stallCount saturates at all-ones; it never wraps.
- Latency: one cycle from ID inputs to ex* outputs.
- A load-use stall lasts exactly one cycle. The bubble clears exMemRead, so loadUse drops next cycle and the held ID instruction advances.
- Simultaneous hold and flush: hold wins. The flush source must hold flush asserted until hold drops.
- Simultaneous flush and loadUse: flush wins; pcWrite stays 1 so the redirect is taken.
- Register 0 as load destination never stalls.
- Mid-operation reset clears a pending bubble and any frozen state on the same edge.

Decomposition:
- Shared package:
  - CTRL_W = 6 and the control-vector bit order {regWrite, memRead, memWrite, memToReg, regDst, ALUSrc}.
  - Opcode constants: RTYPE 000000, LW 100011, SW 101011, J 000010, BEQ 000100, BNE 000101.
  - A zero control-vector constant NOP_CTRL.
- Sub-module: hazard_detect_unit, purely combinational. Computes loadUse, stallReq, pcWrite and ifIdWrite from exValid, exMemRead, exRt, idRs, idRt, flush and hold.
- id_ex_stage holds the register, priority logic and counter.

Test Plan:
- Reset:
  - Stimulus: rst=0 for 2 cycles with nonzero inputs.
  - Response: all ex* 0, exValid 0, stallCount 0, pcWrite=1.
- Normal flow (R-type add):
  - Stimulus: ctrl 100010, readData1=5, readData2=7, rd=3.
  - Response: next cycle exRegWrite=1, exRegDst=1, exData1=5, exData2=7, exRd=3, exValid=1.
- Load-use:
  - Stimulus: LW rt=8 (ctrl 110101), then ADD with rs=8.
  - Response: cycle after LW has pcWrite=ifIdWrite=0. Next edge inserts a bubble (control 0, exValid 0), stallCount=1. The following edge latches the ADD.
- No stall for $0:
  - Stimulus: LW rt=0, then consumer rs=0.
  - Response: pcWrite stays 1; stallCount unchanged.
- Flush vs hazard:
  - Stimulus: LW rt=4 in EX, ID uses rs=4, flush=1 on the same cycle.
  - Response: pcWrite=1, bubble latched, stallCount unchanged.
- Hold and saturation:
  - Stimulus: hold=1 for 3 cycles.
  - Response: ex* frozen, pcWrite=0.
  - Stimulus: preload stallCount near all-ones (CNT_W=4 build), force 20 load-use stalls.
  - Response: stallCount sticks at 15.
